// File: rtl/sprite_motion_ctrl.sv
// Keyboard-driven motion controller for a single sprite, updated once per frame_clk (vsync).
// Each axis carries a signed velocity with acceleration, friction and saturation. SPACE
// toggles pause, and edge_mode chooses what happens at the playfield limits.
//
// Ports:
//   frame_clk  in   frame-rate clock; all state changes on posedge
//   Reset      in   synchronous, active-high
//   keycode    in   8-bit HID keycode (W=1A up, S=16 down, A=04 left, D=07 right, SPACE=2C)
//   edge_mode  in   0 bounce, 1 wrap, 2 clamp, 3 bounce
//   PosX/PosY  out  sprite centre, unsigned 10-bit
//   Size       out  constant sprite half-width
//   VelX/VelY  out  registered signed velocity
//   edge_hit   out  one-frame pulse after any X or Y limit event
//   state      out  FSM state: 0 idle, 1 move, 2 pause
module sprite_motion_ctrl #(
  parameter int unsigned X_CENTER  = 320,
  parameter int unsigned Y_CENTER  = 240,
  parameter int unsigned X_MIN     = 0,
  parameter int unsigned X_MAX     = 639,
  parameter int unsigned Y_MIN     = 0,
  parameter int unsigned Y_MAX     = 479,
  parameter int unsigned SIZE      = 16,
  parameter int unsigned VEL_W     = 6,
  parameter int unsigned MAX_SPEED = 4,
  parameter int unsigned ACCEL     = 1,
  parameter int unsigned FRICTION  = 1
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic [7:0]              keycode,
  input  logic [1:0]              edge_mode,
  output logic [9:0]              PosX,
  output logic [9:0]              PosY,
  output logic [9:0]              Size,
  output logic signed [VEL_W-1:0] VelX,
  output logic signed [VEL_W-1:0] VelY,
  output logic                    edge_hit,
  output logic [1:0]              state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StMove  = 2'd1,
    StPause = 2'd2
  } state_e;

  typedef struct packed {
    logic             hit;
    logic [9:0]       pos;
    logic [VEL_W-1:0] vel;
  } axis_t;

  // All position arithmetic is done in 12-bit signed so n - SIZE can go below zero.
  localparam logic signed [11:0] SizeS  = 12'(SIZE);
  localparam logic signed [11:0] XMinS  = 12'(X_MIN);
  localparam logic signed [11:0] XMaxS  = 12'(X_MAX);
  localparam logic signed [11:0] YMinS  = 12'(Y_MIN);
  localparam logic signed [11:0] YMaxS  = 12'(Y_MAX);
  localparam logic signed [11:0] MaxSpd = 12'(MAX_SPEED);
  localparam logic signed [11:0] AccS   = 12'(ACCEL);
  localparam logic signed [11:0] FricS  = 12'(FRICTION);

  localparam logic [7:0] KeyUp    = 8'h1A;
  localparam logic [7:0] KeyDown  = 8'h16;
  localparam logic [7:0] KeyLeft  = 8'h04;
  localparam logic [7:0] KeyRight = 8'h07;
  localparam logic [7:0] KeySpace = 8'h2C;

  function automatic logic signed [11:0] sext_vel(input logic [VEL_W-1:0] v);
    return {{(12 - VEL_W){v[VEL_W-1]}}, v};
  endfunction

  // One axis of velocity: accelerate toward a held key (through zero, saturating),
  // otherwise decay toward zero by FRICTION.
  function automatic logic [VEL_W-1:0] vel_step(input logic [VEL_W-1:0] v,
                                                input logic inc, input logic dec);
    logic signed [11:0] acc;
    acc = sext_vel(v);
    if (inc) begin
      acc = acc + AccS;
      if (acc > MaxSpd) acc = MaxSpd;
    end else if (dec) begin
      acc = acc - AccS;
      if (acc < -MaxSpd) acc = -MaxSpd;
    end else if ((acc <= FricS) && (acc >= -FricS)) begin
      acc = '0;
    end else if (acc > 0) begin
      acc = acc - FricS;
    end else begin
      acc = acc + FricS;
    end
    return acc[VEL_W-1:0];
  endfunction

  // Advance one axis by its new velocity and resolve limit events. hi and lo are
  // mutually exclusive given MIN+SIZE < MAX-SIZE.
  function automatic axis_t axis_resolve(input logic [9:0] pos, input logic [VEL_W-1:0] v,
                                         input logic signed [11:0] lim_lo,
                                         input logic signed [11:0] lim_hi,
                                         input logic [1:0] mode);
    axis_t              res;
    logic signed [11:0] n;
    logic signed [11:0] lo_pos;
    logic signed [11:0] hi_pos;
    logic [VEL_W-1:0]   absv;
    logic               hi;
    logic               lo;
    n      = $signed({2'b00, pos}) + sext_vel(v);
    lo_pos = lim_lo + SizeS;
    hi_pos = lim_hi - SizeS;
    hi     = (n + SizeS) >= lim_hi;
    lo     = (n - SizeS) <= lim_lo;
    absv   = v[VEL_W-1] ? (~v + 1'b1) : v;
    res.hit = hi | lo;
    res.pos = n[9:0];
    res.vel = v;
    if (hi) begin
      case (mode)
        2'd1:    res.pos = lo_pos[9:0];
        2'd2:    begin res.pos = hi_pos[9:0]; res.vel = '0; end
        default: begin res.pos = hi_pos[9:0]; res.vel = ~absv + 1'b1; end
      endcase
    end else if (lo) begin
      case (mode)
        2'd1:    res.pos = hi_pos[9:0];
        2'd2:    begin res.pos = lo_pos[9:0]; res.vel = '0; end
        default: begin res.pos = lo_pos[9:0]; res.vel = absv; end
      endcase
    end
    return res;
  endfunction

  state_e           r_state;
  state_e           w_state_next;
  logic [9:0]       r_pos_x;
  logic [9:0]       r_pos_y;
  logic [VEL_W-1:0] r_vel_x;
  logic [VEL_W-1:0] r_vel_y;
  logic             r_edge_hit;
  logic             r_space_prev;

  logic [9:0]       w_pos_x_next;
  logic [9:0]       w_pos_y_next;
  logic [VEL_W-1:0] w_vel_x_next;
  logic [VEL_W-1:0] w_vel_y_next;
  logic             w_edge_hit_next;

  logic             w_up;
  logic             w_down;
  logic             w_left;
  logic             w_right;
  logic             w_dir;
  logic             w_space;
  logic             w_space_edge;
  logic             w_run;
  logic [VEL_W-1:0] w_vx_step;
  logic [VEL_W-1:0] w_vy_step;
  axis_t            w_ax;
  axis_t            w_ay;

  assign w_up         = (keycode == KeyUp);
  assign w_down       = (keycode == KeyDown);
  assign w_left       = (keycode == KeyLeft);
  assign w_right      = (keycode == KeyRight);
  assign w_dir        = w_up | w_down | w_left | w_right;
  assign w_space      = (keycode == KeySpace);
  assign w_space_edge = w_space & ~r_space_prev;

  assign w_vx_step = vel_step(r_vel_x, w_right, w_left);
  assign w_vy_step = vel_step(r_vel_y, w_down, w_up);
  assign w_ax      = axis_resolve(r_pos_x, w_vx_step, XMinS, XMaxS, edge_mode);
  assign w_ay      = axis_resolve(r_pos_y, w_vy_step, YMinS, YMaxS, edge_mode);

  // A fresh SPACE press suppresses motion for the frame it arrives in.
  assign w_run = (r_state != StPause) && !w_space_edge;

  always_comb begin
    w_state_next    = r_state;
    w_pos_x_next    = r_pos_x;
    w_pos_y_next    = r_pos_y;
    w_vel_x_next    = r_vel_x;
    w_vel_y_next    = r_vel_y;
    w_edge_hit_next = 1'b0;

    case (r_state)
      StIdle: begin
        if (w_space_edge)  w_state_next = StPause;
        else if (w_dir)    w_state_next = StMove;
      end
      StMove: begin
        if (w_space_edge) begin
          w_state_next = StPause;
        end else if ((w_vx_step == '0) && (w_vy_step == '0) && !w_dir) begin
          w_state_next = StIdle;
        end
      end
      StPause: begin
        if (w_space_edge) begin
          w_state_next = ((r_vel_x | r_vel_y) != '0) ? StMove : StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase

    if (w_run) begin
      w_pos_x_next    = w_ax.pos;
      w_vel_x_next    = w_ax.vel;
      w_pos_y_next    = w_ay.pos;
      w_vel_y_next    = w_ay.vel;
      w_edge_hit_next = w_ax.hit | w_ay.hit;
    end
  end

  always_ff @(posedge frame_clk) begin
    // Tracked through reset so a key held across reset does not look like a new press.
    r_space_prev <= w_space;
    if (Reset) begin
      r_state    <= StIdle;
      r_pos_x    <= 10'(X_CENTER);
      r_pos_y    <= 10'(Y_CENTER);
      r_vel_x    <= '0;
      r_vel_y    <= '0;
      r_edge_hit <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pos_x    <= w_pos_x_next;
      r_pos_y    <= w_pos_y_next;
      r_vel_x    <= w_vel_x_next;
      r_vel_y    <= w_vel_y_next;
      r_edge_hit <= w_edge_hit_next;
    end
  end

  assign PosX     = r_pos_x;
  assign PosY     = r_pos_y;
  assign Size     = 10'(SIZE);
  assign VelX     = r_vel_x;
  assign VelY     = r_vel_y;
  assign edge_hit = r_edge_hit;
  assign state    = r_state;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl with default parameters. Inputs change and outputs
// are sampled 1 time unit after each frame_clk rising edge.
module tb_sprite_motion_ctrl;

  localparam logic [7:0] KNone  = 8'h00;
  localparam logic [7:0] KUp    = 8'h1A;
  localparam logic [7:0] KDown  = 8'h16;
  localparam logic [7:0] KLeft  = 8'h04;
  localparam logic [7:0] KRight = 8'h07;
  localparam logic [7:0] KSpace = 8'h2C;

  logic              frame_clk;
  logic              Reset;
  logic [7:0]        keycode;
  logic [1:0]        edge_mode;
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  logic [9:0]        size;
  logic signed [5:0] vel_x;
  logic signed [5:0] vel_y;
  logic              edge_hit;
  logic [1:0]        state;

  int checks;
  int failures;

  sprite_motion_ctrl dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .edge_mode (edge_mode),
    .PosX      (pos_x),
    .PosY      (pos_y),
    .Size      (size),
    .VelX      (vel_x),
    .VelY      (vel_y),
    .edge_hit  (edge_hit),
    .state     (state)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a keycode for n frames.
  task automatic frames(input logic [7:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      keycode = k;
      @(posedge frame_clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [7:0] k);
    Reset   = 1'b1;
    keycode = k;
    repeat (2) @(posedge frame_clk);
    #1;
    Reset = 1'b0;
  endtask

  // From centre: ends at PosX=620 with VelX=4.
  task automatic run_to_620();
    frames(KRight, 73);  // 330 after build-up, then 69 frames at 4 -> 606
    frames(KNone, 1);    // 609, v3
    frames(KRight, 1);   // 613, v4
    frames(KNone, 1);    // 616, v3
    frames(KRight, 1);   // 620, v4
  endtask

  int exp_acc_v[6]  = '{1, 2, 3, 4, 4, 4};
  int exp_acc_p[6]  = '{321, 323, 326, 330, 334, 338};
  int exp_dec_v[4]  = '{3, 2, 1, 0};
  int exp_dec_p[4]  = '{341, 343, 344, 344};
  int exp_edge_p[3] = '{623, 16, 623};
  int exp_edge_v[3] = '{-4, 4, 0};

  initial begin
    checks    = 0;
    failures  = 0;
    Reset     = 1'b1;
    keycode   = KNone;
    edge_mode = 2'd0;

    // Reset state
    do_reset(KNone);
    check_eq("rst_posx", int'(pos_x), 320);
    check_eq("rst_posy", int'(pos_y), 240);
    check_eq("rst_velx", int'(vel_x), 0);
    check_eq("rst_vely", int'(vel_y), 0);
    check_eq("rst_state", int'(state), 0);
    check_eq("rst_edge", int'(edge_hit), 0);
    check_eq("size", int'(size), 16);

    // Acceleration with saturation, then friction back to rest
    for (int i = 0; i < 6; i++) begin
      frames(KRight, 1);
      check_eq($sformatf("acc_velx%0d", i), int'(vel_x), exp_acc_v[i]);
      check_eq($sformatf("acc_posx%0d", i), int'(pos_x), exp_acc_p[i]);
    end
    check_eq("acc_state", int'(state), 1);
    for (int i = 0; i < 4; i++) begin
      frames(KNone, 1);
      check_eq($sformatf("dec_velx%0d", i), int'(vel_x), exp_dec_v[i]);
      check_eq($sformatf("dec_posx%0d", i), int'(pos_x), exp_dec_p[i]);
      check_eq($sformatf("dec_state%0d", i), int'(state), (i == 3) ? 0 : 1);
    end

    // Right-edge response in bounce, wrap and clamp
    for (int m = 0; m < 3; m++) begin
      do_reset(KNone);
      edge_mode = 2'(m);
      run_to_620();
      check_eq($sformatf("pre_posx_m%0d", m), int'(pos_x), 620);
      check_eq($sformatf("pre_velx_m%0d", m), int'(vel_x), 4);
      check_eq($sformatf("pre_edge_m%0d", m), int'(edge_hit), 0);
      frames(KRight, 1);
      check_eq($sformatf("hit_posx_m%0d", m), int'(pos_x), exp_edge_p[m]);
      check_eq($sformatf("hit_velx_m%0d", m), int'(vel_x), exp_edge_v[m]);
      check_eq($sformatf("hit_edge_m%0d", m), int'(edge_hit), 1);
      // Next frame moves clear of the limit so the pulse must drop.
      frames((m == 2) ? KLeft : KNone, 1);
      check_eq($sformatf("post_edge_m%0d", m), int'(edge_hit), 0);
    end

    // Pause: held SPACE toggles once; state and motion frozen
    do_reset(KNone);
    edge_mode = 2'd0;
    frames(KRight, 3);
    check_eq("pz_velx_pre", int'(vel_x), 3);
    check_eq("pz_posx_pre", int'(pos_x), 326);
    for (int i = 0; i < 3; i++) begin
      frames(KSpace, 1);
      check_eq($sformatf("pz_state%0d", i), int'(state), 2);
      check_eq($sformatf("pz_posx%0d", i), int'(pos_x), 326);
      check_eq($sformatf("pz_velx%0d", i), int'(vel_x), 3);
    end
    frames(KRight, 1);
    check_eq("pz_dir_ignored", int'(pos_x), 326);
    check_eq("pz_dir_state", int'(state), 2);
    frames(KSpace, 1);
    check_eq("unpz_state", int'(state), 1);
    check_eq("unpz_velx", int'(vel_x), 3);
    check_eq("unpz_posx", int'(pos_x), 326);
    frames(KNone, 1);
    check_eq("resume_velx", int'(vel_x), 2);
    check_eq("resume_posx", int'(pos_x), 328);

    // Reset mid-pause with SPACE held: centre, idle, no toggle afterwards
    frames(KSpace, 1);
    check_eq("rp_paused", int'(state), 2);
    do_reset(KSpace);
    check_eq("rp_posx", int'(pos_x), 320);
    check_eq("rp_state", int'(state), 0);
    frames(KSpace, 2);
    check_eq("rp_hold_state", int'(state), 0);
    check_eq("rp_hold_posx", int'(pos_x), 320);
    frames(KNone, 1);
    check_eq("rp_rel_state", int'(state), 0);

    // Corner: X and Y limits crossed in the same frame, bounce mode
    do_reset(KNone);
    edge_mode = 2'd0;
    frames(KDown, 52);  // 448 after release below
    frames(KNone, 4);
    frames(KDown, 3);   // +9 short move -> 457
    frames(KNone, 3);
    check_eq("cn_posy", int'(pos_y), 457);
    check_eq("cn_vely", int'(vel_y), 0);
    for (int i = 0; i < 3; i++) begin
      frames(KRight, 1);  // +1 nudge each
      frames(KNone, 1);
    end
    frames(KRight, 74);  // 323 + 10 + 70*4 = 613
    check_eq("cn_posx", int'(pos_x), 613);
    check_eq("cn_velx", int'(vel_x), 4);
    frames(KDown, 2);    // (616,458) then (618,460)
    frames(KRight, 1);   // (621,461), vx3 vy1
    check_eq("cn_pre_posx", int'(pos_x), 621);
    check_eq("cn_pre_posy", int'(pos_y), 461);
    check_eq("cn_pre_vely", int'(vel_y), 1);
    check_eq("cn_pre_edge", int'(edge_hit), 0);
    frames(KDown, 1);    // n = (623,463): both axes hit
    check_eq("cn_hit_posx", int'(pos_x), 623);
    check_eq("cn_hit_velx", int'(vel_x), -2);
    check_eq("cn_hit_posy", int'(pos_y), 463);
    check_eq("cn_hit_vely", int'(vel_y), -2);
    check_eq("cn_hit_edge", int'(edge_hit), 1);
    frames(KNone, 1);
    check_eq("cn_post_edge", int'(edge_hit), 0);
    check_eq("cn_post_posx", int'(pos_x), 622);
    check_eq("cn_post_posy", int'(pos_y), 462);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
